// File: rtl/register_scoreboard.sv
// register_scoreboard: per-register distance tracker for the 5-stage core.
// Each entry holds how many stages the pending producer of that register
// still is from the register file (3=EX, 2=MEM, 1=WB, 0=committed). The
// array feeds the forwarding unit; a load still in EX that is read by the
// instruction in ID raises the load-use lock.
module register_scoreboard #(
    parameter int NREG      = 8,
    parameter int ISSUE_VAL = 3,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [2:0]            issue_rd,
    input  logic                  issue_is_load,
    input  logic [2:0]            ra,
    input  logic [2:0]            rb,
    input  logic                  use_ra,
    input  logic                  use_rb,
    input  logic                  pipe_stall,
    input  logic                  flush,
    output logic [NREG-1:0][2:0]  register_invalid,
    output logic [NREG-1:0]       load_pending,
    output logic                  lock,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [2:0]       ISSUE_CODE = 3'(ISSUE_VAL);
    localparam logic [2:0]       EX_CODE    = 3'd3;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [NREG-1:0][2:0] invalid_reg;
    logic [NREG-1:0]      load_reg;
    logic [CNT_W-1:0]     stall_count_reg;

    logic ra_hazard;
    logic rb_hazard;
    logic issue_ok;
    logic count_en;

    // Load-use hazard: a source read in ID whose producer is a load still in EX.
    always_comb begin
        ra_hazard = use_ra && (invalid_reg[ra] == EX_CODE) && load_reg[ra];
        rb_hazard = use_rb && (invalid_reg[rb] == EX_CODE) && load_reg[rb];
        lock      = !flush && (ra_hazard || rb_hazard);
        issue_ok  = issue_valid && !lock && !flush && !pipe_stall;
        count_en  = (lock || pipe_stall) && !flush;
    end

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_entry
            // Per-register distance update: stall holds, flush squashes EX,
            // issue loads the entry, otherwise the producer advances one stage.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    invalid_reg[gi] <= 3'd0;
                    load_reg[gi]    <= 1'b0;
                end else if (pipe_stall && !flush) begin
                    invalid_reg[gi] <= invalid_reg[gi];
                    load_reg[gi]    <= load_reg[gi];
                end else if (flush) begin
                    // The producer in EX is squashed; older ones keep moving.
                    if (invalid_reg[gi] == EX_CODE) begin
                        invalid_reg[gi] <= 3'd0;
                        load_reg[gi]    <= 1'b0;
                    end else if (invalid_reg[gi] != 3'd0) begin
                        invalid_reg[gi] <= invalid_reg[gi] - 3'd1;
                        if (invalid_reg[gi] == 3'd1) begin
                            load_reg[gi] <= 1'b0;
                        end
                    end
                end else if (issue_ok && (issue_rd == 3'(gi))) begin
                    // Younger writer replaces whatever was pending here.
                    invalid_reg[gi] <= ISSUE_CODE;
                    load_reg[gi]    <= issue_is_load;
                end else if (invalid_reg[gi] != 3'd0) begin
                    invalid_reg[gi] <= invalid_reg[gi] - 3'd1;
                    if (invalid_reg[gi] == 3'd1) begin
                        load_reg[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // Saturating counter of cycles in which the front end was held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_reg <= '0;
        end else if (count_en && (stall_count_reg != CNT_MAX)) begin
            stall_count_reg <= stall_count_reg + 1'b1;
        end
    end

    assign register_invalid = invalid_reg;
    assign load_pending     = load_reg;
    assign stall_count      = stall_count_reg;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed testbench for register_scoreboard. A second, narrow-counter
// instance exercises stall counter saturation in a few cycles.
module tb_register_scoreboard;

    logic             clk = 1'b0;
    logic             reset;
    logic             issue_valid;
    logic [2:0]       issue_rd;
    logic             issue_is_load;
    logic [2:0]       ra;
    logic [2:0]       rb;
    logic             use_ra;
    logic             use_rb;
    logic             pipe_stall;
    logic             flush;
    logic [7:0][2:0]  register_invalid;
    logic [7:0]       load_pending;
    logic             lock;
    logic [15:0]      stall_count;

    logic             sat_stall;
    logic [7:0][2:0]  sat_invalid;
    logic [7:0]       sat_load_pending;
    logic             sat_lock;
    logic [3:0]       sat_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    register_scoreboard #(.NREG(8), .ISSUE_VAL(3), .CNT_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .issue_valid      (issue_valid),
        .issue_rd         (issue_rd),
        .issue_is_load    (issue_is_load),
        .ra               (ra),
        .rb               (rb),
        .use_ra           (use_ra),
        .use_rb           (use_rb),
        .pipe_stall       (pipe_stall),
        .flush            (flush),
        .register_invalid (register_invalid),
        .load_pending     (load_pending),
        .lock             (lock),
        .stall_count      (stall_count)
    );

    register_scoreboard #(.NREG(8), .ISSUE_VAL(3), .CNT_W(4)) sat_dut (
        .clk              (clk),
        .reset            (reset),
        .issue_valid      (1'b0),
        .issue_rd         (3'd0),
        .issue_is_load    (1'b0),
        .ra               (3'd0),
        .rb               (3'd0),
        .use_ra           (1'b0),
        .use_rb           (1'b0),
        .pipe_stall       (sat_stall),
        .flush            (1'b0),
        .register_invalid (sat_invalid),
        .load_pending     (sat_load_pending),
        .lock             (sat_lock),
        .stall_count      (sat_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    initial begin
        reset = 1'b1; issue_valid = 1'b0; issue_rd = 3'd0; issue_is_load = 1'b0;
        ra = 3'd0; rb = 3'd0; use_ra = 1'b0; use_rb = 1'b0;
        pipe_stall = 1'b0; flush = 1'b0; sat_stall = 1'b0;
        tick(); tick();
        chk("rst_inv", 32'(register_invalid), 32'h0);
        chk("rst_lp", 32'(load_pending), 32'h0);
        chk("rst_cnt", 32'(stall_count), 32'h0);
        reset = 1'b0;

        // Reset mid-run: pending r3 and a nonzero counter are discarded at once.
        issue_valid = 1'b1; issue_rd = 3'd3; pipe_stall = 1'b0;
        tick();
        issue_valid = 1'b0;
        chk("mid_r3", 32'(register_invalid[3]), 32'd3);
        pipe_stall = 1'b1;
        tick();
        pipe_stall = 1'b0;
        chk("mid_cnt", 32'(stall_count), 32'd1);
        chk("mid_r3_hold", 32'(register_invalid[3]), 32'd3);
        reset = 1'b1;
        #1;
        chk("async_inv", 32'(register_invalid), 32'h0);
        chk("async_cnt", 32'(stall_count), 32'h0);
        tick();
        reset = 1'b0;

        // ALU chain on r2, read by ra: never locks.
        issue_valid = 1'b1; issue_rd = 3'd2; issue_is_load = 1'b0;
        tick();
        issue_valid = 1'b0; use_ra = 1'b1; ra = 3'd2;
        #1;
        chk("alu_r2_c1", 32'(register_invalid[2]), 32'd3);
        chk("alu_lock_c1", 32'(lock), 32'd0);
        tick();
        chk("alu_r2_c2", 32'(register_invalid[2]), 32'd2);
        chk("alu_lock_c2", 32'(lock), 32'd0);
        tick();
        chk("alu_r2_c3", 32'(register_invalid[2]), 32'd1);
        tick();
        chk("alu_r2_c4", 32'(register_invalid[2]), 32'd0);
        use_ra = 1'b0;

        // Load-use on r5 read via rb; a concurrent issue of r6 is blocked.
        issue_valid = 1'b1; issue_rd = 3'd5; issue_is_load = 1'b1;
        tick();
        chk("ld_r5", 32'(register_invalid[5]), 32'd3);
        chk("ld_lp5", 32'(load_pending[5]), 32'd1);
        issue_rd = 3'd6; issue_is_load = 1'b0; use_rb = 1'b1; rb = 3'd5;
        #1;
        chk("ld_lock_on", 32'(lock), 32'd1);
        tick();
        chk("ld_lock_off", 32'(lock), 32'd0);
        issue_valid = 1'b0; use_rb = 1'b0;
        chk("ld_r5_dec", 32'(register_invalid[5]), 32'd2);
        chk("ld_r6_blk", 32'(register_invalid[6]), 32'd0);
        chk("ld_cnt", 32'(stall_count), 32'd1);
        tick(); tick();
        chk("ld_r5_done", 32'(register_invalid[5]), 32'd0);
        chk("ld_lp5_clr", 32'(load_pending[5]), 32'd0);

        // pipe_stall holds r1 at 2 for three cycles.
        issue_valid = 1'b1; issue_rd = 3'd1; issue_is_load = 1'b0;
        tick();
        issue_valid = 1'b0;
        tick();
        chk("stl_r1_pre", 32'(register_invalid[1]), 32'd2);
        pipe_stall = 1'b1;
        tick();
        chk("stl_r1_h1", 32'(register_invalid[1]), 32'd2);
        tick();
        tick();
        chk("stl_r1_h3", 32'(register_invalid[1]), 32'd2);
        chk("stl_cnt", 32'(stall_count), 32'd4);
        pipe_stall = 1'b0;
        tick();
        chk("stl_r1_rel1", 32'(register_invalid[1]), 32'd1);
        tick();
        chk("stl_r1_rel2", 32'(register_invalid[1]), 32'd0);

        // Flush with r4=3 (load), r6=2, issue r7 attempted, pipe_stall also high.
        issue_valid = 1'b1; issue_rd = 3'd6; issue_is_load = 1'b0;
        tick();
        issue_rd = 3'd4; issue_is_load = 1'b1;
        tick();
        chk("fl_r4_pre", 32'(register_invalid[4]), 32'd3);
        chk("fl_r6_pre", 32'(register_invalid[6]), 32'd2);
        issue_rd = 3'd7; issue_is_load = 1'b0; flush = 1'b1; pipe_stall = 1'b1;
        use_ra = 1'b1; ra = 3'd4;
        #1;
        chk("fl_lock", 32'(lock), 32'd0);
        tick();
        flush = 1'b0; pipe_stall = 1'b0; issue_valid = 1'b0; use_ra = 1'b0;
        chk("fl_r4", 32'(register_invalid[4]), 32'd0);
        chk("fl_lp4", 32'(load_pending[4]), 32'd0);
        chk("fl_r6", 32'(register_invalid[6]), 32'd1);
        chk("fl_r7", 32'(register_invalid[7]), 32'd0);
        chk("fl_cnt", 32'(stall_count), 32'd4);

        // WAW: back-to-back issue of r0 restarts its countdown.
        issue_valid = 1'b1; issue_rd = 3'd0;
        tick();
        chk("waw_c1", 32'(register_invalid[0]), 32'd3);
        tick();
        issue_valid = 1'b0;
        chk("waw_c2", 32'(register_invalid[0]), 32'd3);
        tick();
        chk("waw_c3", 32'(register_invalid[0]), 32'd2);
        tick();
        chk("waw_c4", 32'(register_invalid[0]), 32'd1);
        tick();
        chk("waw_c5", 32'(register_invalid[0]), 32'd0);

        // Saturation on the 4-bit counter instance.
        sat_stall = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_14", 32'(sat_count), 32'd14);
        tick();
        chk("sat_15", 32'(sat_count), 32'd15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_hold", 32'(sat_count), 32'd15);
        sat_stall = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
